// File: rtl/des_key_schedule.sv
// DES subkey generator: emits the sixteen 48-bit round keys of FIPS 46-3
// one per handshake, forward (K1..K16) for encryption or reversed
// (K16..K1) for decryption, using left or right rotations of C/D.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  key_num,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Rotation amount that produces Kn from Kn-1, indexed 0 = K1 .. 15 = K16.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [27:0] c_d, d_d;
    logic        dir_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  key_num_q;
    logic [3:0]  key_num_inc;
    logic [55:0] cd_load;
    logic        hs;
    logic        last;
    logic        parity_unused;

    // Permuted choice 1: bit n of the result (DES numbering) is key bit PC1[n].
    // DES bit b lives at key_in[64-b]; the literal indices below are 64-b.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {
            // C half: 57 49 41 33 25 17 9 1 58 50 42 34 26 18 10 2 59 51 43 35 27 19 11 3 60 52 44 36
            k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
            k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
            k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
            k[4],  k[12], k[20], k[28],
            // D half: 63 55 47 39 31 23 15 7 62 54 46 38 30 22 14 6 61 53 45 37 29 21 13 5 28 20 12 4
            k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
            k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
            k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
            k[36], k[44], k[52], k[60]
        };
    endfunction

    // Permuted choice 2 over {C,D}: CD bit b lives at cd[56-b].
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        return {
            // 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2
            cd[42], cd[39], cd[45], cd[32], cd[55], cd[51], cd[53], cd[28],
            cd[41], cd[50], cd[35], cd[46], cd[33], cd[37], cd[44], cd[52],
            cd[30], cd[48], cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
            // 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32
            cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],  cd[26], cd[16],
            cd[5],  cd[11], cd[23], cd[8],  cd[12], cd[7],  cd[17], cd[0],
            cd[22], cd[3],  cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]
        };
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign cd_load       = pc1(key_in);
    // Parity bits take no part in the schedule.
    assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    assign hs          = valid_q & subkey_ready;
    assign last        = dir_q ? (key_num_q == 4'd0) : (key_num_q == 4'd15);
    assign key_num_inc = key_num_q + 4'd1;

    // Next C/D: load (pre-rotated once for K1 when encrypting), then step on each accepted key.
    always_comb begin
        c_d = c_q;
        d_d = d_q;
        if (state_q == S_IDLE && start) begin
            if (decrypt) begin
                // C16/D16 equal C0/D0, so K16 comes straight from the load.
                c_d = cd_load[55:28];
                d_d = cd_load[27:0];
            end else begin
                c_d = rotl(cd_load[55:28], 2'd1);
                d_d = rotl(cd_load[27:0], 2'd1);
            end
        end else if (state_q == S_ROUND && hs && !last) begin
            if (dir_q) begin
                // Undo the rotation that produced the current key.
                c_d = rotr(c_q, SHIFT[key_num_q]);
                d_d = rotr(d_q, SHIFT[key_num_q]);
            end else begin
                c_d = rotl(c_q, SHIFT[key_num_inc]);
                d_d = rotl(d_q, SHIFT[key_num_inc]);
            end
        end
    end

    // Control FSM with registered handshake/status outputs and C/D state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            c_q       <= 28'd0;
            d_q       <= 28'd0;
            dir_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            key_num_q <= 4'd0;
        end else begin
            c_q <= c_d;
            d_q <= d_d;
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dir_q     <= decrypt;
                        key_num_q <= decrypt ? 4'd15 : 4'd0;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (hs) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            key_num_q <= dir_q ? (key_num_q - 4'd1) : key_num_inc;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign subkey       = pc2({c_q, d_q});
    assign subkey_valid = valid_q;
    assign key_num      = key_num_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
